// File: rtl/otp_ctrl_ecc_pkg.sv
// Shared types for the OTP ECC register array arbiter and its scrub engine.
package otp_ctrl_ecc_pkg;

  localparam int unsigned DepthDef = 15;
  localparam int unsigned WidthDef = 32;
  localparam int unsigned CntWDef  = 8;

  typedef enum logic [1:0] {
    EccOk      = 2'b00,
    EccCorr    = 2'b01,
    EccUnc     = 2'b10,
    EccAddrErr = 2'b11
  } ecc_err_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCheck,
    StWb,
    StDone
  } scrub_state_e;

endpackage

// File: rtl/otp_ctrl_ecc_scrub_fsm.sv
// Scrub sequencer: walks entries 0..Depth-1, rewrites correctable words and
// counts correctable/uncorrectable errors with saturating counters.
module otp_ctrl_ecc_scrub_fsm
  import otp_ctrl_ecc_pkg::*;
#(
  parameter int unsigned Depth = DepthDef,
  parameter int unsigned Width = WidthDef,
  parameter int unsigned CntW  = CntWDef,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             host_req_i,
  input  logic [Width-1:0] ecc_rdata_i,
  input  logic [1:0]       ecc_err_i,
  output logic             rd_o,
  output logic             wb_o,
  output logic [AddrW-1:0] addr_o,
  output logic [Width-1:0] wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CntW-1:0]  corr_cnt_o,
  output logic [CntW-1:0]  unc_cnt_o
);

  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  scrub_state_e     state_q;
  logic [AddrW-1:0] addr_q;
  logic [Width-1:0] wb_data_q;
  logic [CntW-1:0]  corr_cnt_q, unc_cnt_q;
  logic             busy_q, done_q;
  logic             last_entry;

  assign last_entry = (addr_q == LastAddr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wb_data_q  <= '0;
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= StRead;
          end
        end
        // The host owns the port whenever it asks; the scrub read simply waits.
        StRead: begin
          if (!host_req_i) state_q <= StCheck;
        end
        StCheck: begin
          if (ecc_err_i == EccCorr) begin
            if (corr_cnt_q != '1) corr_cnt_q <= corr_cnt_q + CntW'(1);
            wb_data_q <= ecc_rdata_i;
            state_q   <= StWb;
          end else begin
            if (ecc_err_i == EccUnc && unc_cnt_q != '1) unc_cnt_q <= unc_cnt_q + CntW'(1);
            if (last_entry) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + AddrW'(1);
              state_q <= StRead;
            end
          end
        end
        StWb: begin
          if (last_entry) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            addr_q  <= addr_q + AddrW'(1);
            state_q <= StRead;
          end
        end
        StDone: begin
          addr_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_o       = (state_q == StRead) && !host_req_i;
  assign wb_o       = (state_q == StWb);
  assign addr_o     = addr_q;
  assign wdata_o    = wb_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign corr_cnt_o = corr_cnt_q;
  assign unc_cnt_o  = unc_cnt_q;

endmodule

// File: rtl/otp_ctrl_ecc_scrub_arb.sv
// Shares the single ECC array port between the host and the scrub engine and
// returns host responses one cycle after grant.
module otp_ctrl_ecc_scrub_arb
  import otp_ctrl_ecc_pkg::*;
#(
  parameter int unsigned Depth = DepthDef,
  parameter int unsigned Width = WidthDef,
  parameter int unsigned CntW  = CntWDef,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             host_req_i,
  input  logic             host_we_i,
  input  logic [AddrW-1:0] host_addr_i,
  input  logic [Width-1:0] host_wdata_i,
  output logic             host_gnt_o,
  output logic             host_rvalid_o,
  output logic [Width-1:0] host_rdata_o,
  output logic [1:0]       host_err_o,
  input  logic             scrub_start_i,
  output logic             scrub_busy_o,
  output logic             scrub_done_o,
  output logic [CntW-1:0]  scrub_corr_cnt_o,
  output logic [CntW-1:0]  scrub_unc_cnt_o,
  output logic             ecc_req_o,
  output logic             ecc_we_o,
  output logic [AddrW-1:0] ecc_addr_o,
  output logic [Width-1:0] ecc_wdata_o,
  input  logic [Width-1:0] ecc_rdata_i,
  input  logic [1:0]       ecc_err_i
);

  localparam logic [AddrW:0] DepthExt = (AddrW + 1)'(Depth);

  logic             scrub_rd, scrub_wb;
  logic [AddrW-1:0] scrub_addr;
  logic [Width-1:0] scrub_wdata;
  logic             host_oor, host_issue;
  logic             rsp_valid_q, rsp_rd_q, rsp_oor_q;

  otp_ctrl_ecc_scrub_fsm #(
    .Depth (Depth),
    .Width (Width),
    .CntW  (CntW)
  ) u_scrub_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (scrub_start_i),
    .host_req_i  (host_req_i),
    .ecc_rdata_i (ecc_rdata_i),
    .ecc_err_i   (ecc_err_i),
    .rd_o        (scrub_rd),
    .wb_o        (scrub_wb),
    .addr_o      (scrub_addr),
    .wdata_o     (scrub_wdata),
    .busy_o      (scrub_busy_o),
    .done_o      (scrub_done_o),
    .corr_cnt_o  (scrub_corr_cnt_o),
    .unc_cnt_o   (scrub_unc_cnt_o)
  );

  // Writeback is the only cycle the scrub outranks the host; scrub reads
  // already yield whenever host_req_i is high.
  assign host_gnt_o = host_req_i & ~scrub_wb;
  assign host_oor   = ({1'b0, host_addr_i} >= DepthExt);
  assign host_issue = host_gnt_o & ~host_oor;

  always_comb begin
    ecc_req_o   = 1'b0;
    ecc_we_o    = 1'b0;
    ecc_addr_o  = '0;
    ecc_wdata_o = '0;
    if (scrub_wb) begin
      ecc_req_o   = 1'b1;
      ecc_we_o    = 1'b1;
      ecc_addr_o  = scrub_addr;
      ecc_wdata_o = scrub_wdata;
    end else if (host_issue) begin
      ecc_req_o   = 1'b1;
      ecc_we_o    = host_we_i;
      ecc_addr_o  = host_addr_i;
      ecc_wdata_o = host_we_i ? host_wdata_i : '0;
    end else if (scrub_rd) begin
      ecc_req_o  = 1'b1;
      ecc_addr_o = scrub_addr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_oor_q   <= 1'b0;
    end else begin
      rsp_valid_q <= host_gnt_o;
      rsp_rd_q    <= host_issue & ~host_we_i;
      rsp_oor_q   <= host_gnt_o & host_oor;
    end
  end

  always_comb begin
    host_rvalid_o = rsp_valid_q;
    host_rdata_o  = rsp_rd_q ? ecc_rdata_i : '0;
    if (rsp_oor_q)      host_err_o = EccAddrErr;
    else if (rsp_rd_q)  host_err_o = ecc_err_i;
    else                host_err_o = EccOk;
  end

endmodule

// File: tb/tb_otp_ctrl_ecc_scrub_arb.sv
// Bench for otp_ctrl_ecc_scrub_arb: behavioural array, host scoreboard and
// directed scrub scenarios.
module tb_otp_ctrl_ecc_scrub_arb;

  localparam int Depth = 15;
  localparam int Width = 32;
  localparam int CntW  = 8;
  localparam int AddrW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             host_req, host_we;
  logic [AddrW-1:0] host_addr;
  logic [Width-1:0] host_wdata;
  logic             host_gnt, host_rvalid;
  logic [Width-1:0] host_rdata;
  logic [1:0]       host_err;
  logic             scrub_start, scrub_busy, scrub_done;
  logic [CntW-1:0]  corr_cnt, unc_cnt;
  logic             ecc_req, ecc_we;
  logic [AddrW-1:0] ecc_addr;
  logic [Width-1:0] ecc_wdata;
  logic [Width-1:0] ecc_rdata = '0;
  logic [1:0]       ecc_err = 2'b00;

  always #5 clk = ~clk;

  otp_ctrl_ecc_scrub_arb #(
    .Depth (Depth),
    .Width (Width),
    .CntW  (CntW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .host_req_i       (host_req),
    .host_we_i        (host_we),
    .host_addr_i      (host_addr),
    .host_wdata_i     (host_wdata),
    .host_gnt_o       (host_gnt),
    .host_rvalid_o    (host_rvalid),
    .host_rdata_o     (host_rdata),
    .host_err_o       (host_err),
    .scrub_start_i    (scrub_start),
    .scrub_busy_o     (scrub_busy),
    .scrub_done_o     (scrub_done),
    .scrub_corr_cnt_o (corr_cnt),
    .scrub_unc_cnt_o  (unc_cnt),
    .ecc_req_o        (ecc_req),
    .ecc_we_o         (ecc_we),
    .ecc_addr_o       (ecc_addr),
    .ecc_wdata_o      (ecc_wdata),
    .ecc_rdata_i      (ecc_rdata),
    .ecc_err_i        (ecc_err)
  );

  // Behavioural array: 1-cycle read latency, a write heals the entry's error.
  logic [Width-1:0] mem    [Depth];
  logic [1:0]       errtab [Depth];
  logic             poke_en = 1'b0;
  logic [AddrW-1:0] poke_addr;
  logic [Width-1:0] poke_data;
  logic [1:0]       poke_err;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr]    <= poke_data;
      errtab[poke_addr] <= poke_err;
    end else if (rst_n && ecc_req && int'(ecc_addr) < Depth) begin
      if (ecc_we) begin
        mem[ecc_addr]    <= ecc_wdata;
        errtab[ecc_addr] <= 2'b00;
      end else begin
        ecc_rdata <= mem[ecc_addr];
        ecc_err   <= errtab[ecc_addr];
      end
    end
  end

  typedef struct {
    int               due;
    logic             chk_data;
    logic [Width-1:0] data;
    logic [1:0]       err;
  } exp_t;

  exp_t             sb[$];
  int               n_chk = 0, n_pass = 0;
  int               cyc = 0, gnt_cnt = 0;
  int               scrub_reads = 0, scrub_exp = 0, order_err = 0, wb_cnt = 0;
  logic [AddrW-1:0] wb_addr;
  logic [Width-1:0] wb_data;
  logic             done_now = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at the falling edge: classify this cycle's traffic, retire responses.
  task automatic sample();
    exp_t e;
    done_now = scrub_done;
    if (scrub_start && !scrub_busy) begin
      scrub_reads = 0; scrub_exp = 0; order_err = 0; wb_cnt = 0;
    end
    if (host_req && host_gnt) begin
      gnt_cnt++;
      e.due = cyc + 1;
      if (int'(host_addr) >= Depth) begin
        check("oor_no_access", {63'd0, ecc_req}, 64'd0);
        e.chk_data = 1'b1; e.data = '0; e.err = 2'b11;
      end else if (host_we) begin
        e.chk_data = 1'b0; e.data = '0; e.err = 2'b00;
      end else begin
        e.chk_data = 1'b1; e.data = mem[host_addr]; e.err = errtab[host_addr];
      end
      sb.push_back(e);
    end else if (ecc_req) begin
      if (ecc_we) begin
        wb_cnt++; wb_addr = ecc_addr; wb_data = ecc_wdata;
      end else begin
        if (int'(ecc_addr) != scrub_exp) order_err++;
        scrub_reads++; scrub_exp++;
      end
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rvalid", {63'd0, host_rvalid}, 64'd1);
      check("rsp_err", {62'd0, host_err}, {62'd0, e.err});
      if (e.chk_data) check("rsp_rdata", {32'd0, host_rdata}, {32'd0, e.data});
    end else if (rst_n) begin
      check("no_spurious_rvalid", {63'd0, host_rvalid}, 64'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic poke(input int a, input logic [Width-1:0] d, input logic [1:0] er);
    poke_addr = AddrW'(a); poke_data = d; poke_err = er; poke_en = 1'b1;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic host_op(input logic we, input int a, input logic [Width-1:0] d);
    host_req = 1'b1; host_we = we; host_addr = AddrW'(a); host_wdata = d;
    tick();
    host_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (done_now) break;
    end
    if (!done_now) check(tag, 64'd0, 64'd1);
  endtask

  task automatic run_scrub(input int exp_cyc, input int exp_wb, input int exp_corr,
                           input int exp_unc);
    int n;
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    check("busy_after_start", {63'd0, scrub_busy}, 64'd1);
    wait_done("done_timeout", n);
    check("scrub_cycles", 64'(n), 64'(exp_cyc));
    check("busy_after_done", {63'd0, scrub_busy}, 64'd0);
    check("done_one_cycle", {63'd0, scrub_done}, 64'd0);
    check("scrub_reads", 64'(scrub_reads), 64'(Depth));
    check("scrub_order", 64'(order_err), 64'd0);
    check("scrub_wb_cnt", 64'(wb_cnt), 64'(exp_wb));
    check("corr_cnt", 64'(corr_cnt), 64'(exp_corr));
    check("unc_cnt", 64'(unc_cnt), 64'(exp_unc));
  endtask

  initial begin
    int n, g0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; scrub_start = 1'b0;
    for (int i = 0; i < Depth; i++) poke(i, 32'hC0DE_0000 | 32'(i), 2'b00);
    poke(3, 32'hA5A5_A5A5, 2'b00);
    @(negedge clk);
    check("reset_host", {28'd0, host_gnt, host_rvalid, host_rdata, host_err}, 64'd0);
    check("reset_scrub", {46'd0, scrub_busy, scrub_done, corr_cnt, unc_cnt}, 64'd0);
    check("reset_ecc", {26'd0, ecc_req, ecc_we, ecc_addr, ecc_wdata}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Host read, out-of-range accesses, write then read back, back-to-back reads.
    host_op(1'b0, 3, '0);
    tick();
    check("read3_data", {32'd0, mem[3]}, 64'hA5A5_A5A5);
    host_op(1'b0, 15, '0);
    host_op(1'b1, 15, 32'hDEAD_BEEF);
    host_op(1'b1, 7, 32'h1234_5678);
    host_op(1'b0, 7, '0);
    tick();
    check("write7_mem", {32'd0, mem[7]}, 64'h1234_5678);
    host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_addr = AddrW'(i);
      tick();
    end
    host_req = 1'b0;
    tick();

    // Clean scrub pass: 2 cycles per entry plus Done.
    run_scrub(31, 0, 0, 0);

    // Correctable at 5 (rewritten with corrected data), uncorrectable at 9.
    poke(5, 32'h5555_0005, 2'b01);
    poke(9, 32'h9999_0009, 2'b10);
    run_scrub(32, 1, 1, 1);
    check("wb_addr5", 64'(wb_addr), 64'd5);
    check("wb_data5", {32'd0, wb_data}, 64'h5555_0005);
    check("entry9_kept", {62'd0, errtab[9]}, 64'd2);

    // Continuous host traffic stalls the scrub, which then completes the pass.
    g0 = gnt_cnt;
    scrub_start = 1'b1; host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      host_addr = AddrW'(i % Depth);
      tick();
      scrub_start = 1'b0;
    end
    host_req = 1'b0;
    check("stall_no_scrub_reads", 64'(scrub_reads), 64'd0);
    check("stall_host_gnts", 64'(gnt_cnt - g0), 64'd20);
    check("stall_busy", {63'd0, scrub_busy}, 64'd1);
    wait_done("stall_done_timeout", n);
    check("stall_scrub_reads", 64'(scrub_reads), 64'(Depth));
    check("stall_order", 64'(order_err), 64'd0);
    check("stall_unc_cleared", 64'(unc_cnt), 64'd1);

    // Host held off for exactly the writeback cycle.
    poke(2, 32'h2222_0002, 2'b01);
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    for (int i = 0; i < 50 && scrub_reads < 3; i++) tick();
    g0 = gnt_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = AddrW'(6);
    for (int i = 0; i < 6; i++) tick();
    host_req = 1'b0;
    check("wb_holdoff_gnts", 64'(gnt_cnt - g0), 64'd5);
    check("wb_holdoff_wb", 64'(wb_cnt), 64'd1);
    check("wb_addr2", 64'(wb_addr), 64'd2);
    wait_done("wb_done_timeout", n);
    check("wb_pass_reads", 64'(scrub_reads), 64'(Depth));
    check("wb_pass_corr", 64'(corr_cnt), 64'd1);

    // Reset during writeback: nothing written, state cleared asynchronously.
    poke(4, 32'h4444_0004, 2'b01);
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      sample();
      if (ecc_we) begin
        n = 1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("saw_wb_before_reset", 64'(n), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_no_we", {62'd0, ecc_req, ecc_we}, 64'd0);
    check("rst_scrub", {46'd0, scrub_busy, scrub_done, corr_cnt, unc_cnt}, 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    check("rst_entry4_unwritten", {62'd0, errtab[4]}, 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    run_scrub(32, 1, 1, 1);
    check("post_rst_wb_addr", 64'(wb_addr), 64'd4);

    tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/otp_ctrl_ecc_scrub_arb.md
Name: otp_ctrl_ecc_scrub_arb

Overview:
Arbiter and scrub sequencer in front of one Depth-entry ECC-protected register array (otp_ctrl_ecc_reg style). It shares the array's single access port between a host read/write port and an internal scrub engine. The scrub engine walks every entry, rewrites entries with correctable errors and counts uncorrectable ones. It sits between the OTP controller partition logic and the array.

Parameters:
Depth, 15, number of array entries; AddrW = $clog2(Depth) (4 at default)
Width, 32, data word width (corrected data, ECC bits internal to array)
CntW, 8, width of scrub error counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
host_req_i  in  1  host access request, held until granted
host_we_i  in  1  1 = write, 0 = read
host_addr_i  in  AddrW  host entry address
host_wdata_i  in  Width  host write data
host_gnt_o  out  1  request accepted this cycle
host_rvalid_o  out  1  read response / write ack valid
host_rdata_o  out  Width  corrected read data
host_err_o  out  2  response error: 00 ok, 01 corrected, 10 uncorrectable, 11 address out of range
scrub_start_i  in  1  pulse: start one full scrub pass
scrub_busy_o  out  1  scrub pass in progress
scrub_done_o  out  1  one-cycle pulse at pass end
scrub_corr_cnt_o  out  CntW  correctable errors found in last/current pass, saturating
scrub_unc_cnt_o  out  CntW  uncorrectable errors in last/current pass, saturating
ecc_req_o  out  1  array access strobe
ecc_we_o  out  1  array write
ecc_addr_o  out  AddrW  array address
ecc_wdata_o  out  Width  array write data
ecc_rdata_i  in  Width  array read data (corrected), valid 1 cycle after read req
ecc_err_i  in  2  array error status with rdata: 00 ok, 01 correctable, 10 uncorrectable

Behaviour:
- Reset: all outputs 0; FSM Idle; scrub address 0; counters 0.
- One array access per cycle at most; array read latency exactly 1 cycle.
- Arbitration: host has fixed priority over scrub. host_gnt_o = host_req_i whenever no scrub writeback or read is outstanding in the response cycle (see below). It is combinational on host_req_i.
- Host read: gnt cycle T drives ecc_req/addr. At T+1: host_rvalid_o=1, rdata=ecc_rdata_i, err=ecc_err_i. Host writes get rvalid at T+1 with err=00. Pipelined: back-to-back host grants allowed every cycle.
- Host address >= Depth: granted, no array access, rvalid at T+1 with err=11 and rdata=0.
- Scrub FSM states: Idle, Read, Check, Wb, Done.
  - Idle: on scrub_start_i, clear both counters, addr=0, go to Read. scrub_busy_o=1 in all states except Idle.
  - Read: if host_req_i is high, stall (no access). Otherwise issue read at scrub addr, go to Check.
  - Check: consume ecc_err_i. On 01: corr_cnt++, latch rdata, go to Wb. On 10: unc_cnt++, no writeback. On 00: nothing. For 00/10: if addr==Depth-1 go to Done, else addr++ and go to Read.
  - Wb: has priority over the host for this one cycle (host_gnt_o=0). Write latched data to the same addr, then advance as in Check.
  - Done: scrub_done_o=1 for one cycle, addr=0, go to Idle.
- Host grant is also withheld in Read→Check issue cycles only if the scrub issued; host and scrub never both issue in one cycle.
- scrub_start_i while busy: ignored. Counters saturate at 2^CntW-1. Counters hold their value after Done until the next start.
- Address wrap: scrub covers exactly 0..Depth-1, not 2^AddrW-1.
- Async reset mid-pass: immediate return to Idle, counters cleared, no writeback completes.

Decomposition:
- Package otp_ctrl_ecc_pkg: typedef ecc_err_e (EccOk, EccCorr, EccUnc, EccAddrErr), scrub_state_e, CntW default.
- Sub-module otp_ctrl_ecc_scrub_fsm: scrub state, address and counters. Top level holds arbitration and the response pipeline.

Test Plan:
- Reset then idle: all outputs 0; host read addr 3 with ecc_err_i=00, rdata 0xA5A5A5A5 → rvalid next cycle, rdata 0xA5A5A5A5, err 00.
- Host read addr 15 (Depth=15) → no ecc_req_o; rvalid next cycle with err 11, rdata 0.
- Scrub pass, no errors → 15 reads at addr 0..14; done pulse 31 cycles after start (2 cycles/entry plus Done); counts 0/0.
- Scrub with error 01 injected at addr 5 → write to addr 5 of the corrected data in the Wb cycle; corr_cnt=1. Error 10 at addr 9 → no write; unc_cnt=1.
- Continuous host_req during scrub → scrub stalls in Read; host served every cycle. Host release → scrub resumes and still covers all 15 entries. Host held off only during Wb.
- rst_ni asserted while in Wb → no ecc_we_o; busy 0; counters 0 asynchronously. A later start runs a full pass from addr 0.
